id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ID inputs: id_valid 1, id_aluop 4, id_rs 5, id_rt 5, id_dst 5, id_rs_data 32, id_rt_data 32, id_imm 32, id_use_imm 1, id_rt_used 1, id_reg_write 1, id_mem_read 1, id_mem_write 1.
REQ-003 SHALL have control input flush  in  1  kills the instruction currently in ID.
REQ-004 SHALL have bypass inputs: exm_reg_write 1, exm_dst 5, exm_result 32, mwb_reg_write 1, mwb_dst 5, mwb_result 32.
REQ-005 SHALL have outputs: id_stall 1, ex_valid 1, ex_aluop 4, ex_input1 32, ex_input2 32, ex_store_data 32, ex_dst 5, ex_reg_write 1, ex_mem_read 1, ex_mem_write 1.

Function
REQ-006 SHALL register all ID inputs into the EX stage on each clk edge, unless a bubble is inserted.
REQ-007 SHALL insert a bubble (ex_valid=0; ex_reg_write, ex_mem_read, ex_mem_write all 0) when flush=1, id_valid=0, or id_stall=1.
REQ-008 SHALL detect a load-use hazard when ex_valid & ex_mem_read & ex_dst!=0 & id_valid & (ex_dst==id_rs | (id_rt_used & ex_dst==id_rt)).
REQ-009 SHALL assert id_stall combinationally on a hazard; SHALL force id_stall=0 when flush=1 (flush wins).
REQ-010 SHALL derive each EX operand (rs, rt) combinationally from the registered data through the forward select.
- Select EX/MEM: exm_reg_write & exm_dst!=0 & exm_dst==src.
- Otherwise select MEM/WB: mwb_reg_write & mwb_dst!=0 & mwb_dst==src.
- Otherwise select the registered value.
REQ-011 EX/MEM SHALL take priority over MEM/WB when both match.
REQ-012 SHALL never forward to register 0.
REQ-013 ex_input1 SHALL be the forwarded rs operand.
REQ-014 ex_input2 SHALL be the registered imm when ex_use_imm=1, else the forwarded rt operand.
REQ-015 ex_store_data SHALL always be the forwarded rt operand.
REQ-016 ex_aluop SHALL be registered id_aluop and SHALL be 4'b0 (ALU_ADD) in a bubble.
REQ-017 SHALL have a latency of 1 cycle from ID to EX.
REQ-018 A stall SHALL hold no internal state beyond the bubble; the ID instruction re-presents next cycle.

Reset
REQ-019 On rst_n=0, asynchronously, SHALL clear all EX registers to 0 (ex_valid=0, all controls 0, data 0).
REQ-020 id_stall SHALL be 0 while in reset.
REQ-021 Reset mid-stall SHALL discard the stalled context.

Configuration
REQ-022 Macro FORWARD_EN SHALL control forwarding.
- Defined: behaviour per REQ-010..012.
- Undefined: operands SHALL be registered values only, and id_stall SHALL also assert on any RAW match (dst!=0, reg_write) of id_rs, or of id_rt when id_rt_used, against the EX, EX/MEM, or MEM/WB stage.

Structure
REQ-023 ALU opcode constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI) and the register-index width SHALL reside in the shared package alu_defs_pkg.
REQ-024 Hazard and forward comparison logic SHALL be the sub-module fwd_unit; the pipeline register SHALL remain in id_ex_stage.

Verification
REQ-025 Scenario: ADD r3=r1+r2 with rs_data 5, rt_data 7 and no hazards -> next cycle ex_input1=5, ex_input2=7, ex_dst=3, ex_valid=1.
REQ-026 Scenario: exm_dst=1 (0x10), mwb_dst=1 (0x20), ID rs=1 -> ex_input1=0x10.
REQ-027 Scenario: LW r4 in EX, ID uses rs=4 -> id_stall=1 for one cycle, then ex_valid=0, then the instruction enters with the MEM/WB-forwarded value.
REQ-028 Scenario: flush=1 coincident with a load-use hazard -> id_stall=0, next ex_valid=0.
REQ-029 Scenario: exm_dst=0 with exm_reg_write=1 and ID rs=0 -> ex_input1 is the registered value 0.
REQ-030 Scenario: rst_n low during stall -> all outputs 0 immediately; the first instruction after release passes normally.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// Shared ALU opcodes, register/data widths, EX pipeline register layout and
// the register-match helpers used by the hazard/forwarding logic.
package alu_defs_pkg;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_SLT = 4'd4,
      ALU_LUI = 4'd5
   } alu_op_e;

   typedef logic [REG_W-1:0]  reg_idx_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] aluop;
      reg_idx_t   rs;
      reg_idx_t   rt;
      reg_idx_t   dst;
      data_t      rs_data;
      data_t      rt_data;
      data_t      imm;
      logic       use_imm;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
   } ex_reg_t;

   // A producer only matches when it writes a real register (r0 is hardwired).
   function automatic logic reg_hit(reg_idx_t src, logic we, reg_idx_t dst);
      return we && (dst != '0) && (dst == src);
   endfunction

   function automatic data_t fwd_pick(reg_idx_t src, data_t regval,
                                      logic exm_we, reg_idx_t exm_dst, data_t exm_res,
                                      logic mwb_we, reg_idx_t mwb_dst, data_t mwb_res);
      if (reg_hit(src, exm_we, exm_dst)) return exm_res;
      if (reg_hit(src, mwb_we, mwb_dst)) return mwb_res;
      return regval;
   endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX bundle: ID instruction fields, flush, bypass buses and EX outputs.
interface id_ex_stage_if;
   import alu_defs_pkg::*;

   logic       id_valid;
   logic [3:0] id_aluop;
   reg_idx_t   id_rs, id_rt, id_dst;
   data_t      id_rs_data, id_rt_data, id_imm;
   logic       id_use_imm, id_rt_used, id_reg_write, id_mem_read, id_mem_write;
   logic       flush;
   logic       exm_reg_write, mwb_reg_write;
   reg_idx_t   exm_dst, mwb_dst;
   data_t      exm_result, mwb_result;
   logic       id_stall;
   logic       ex_valid;
   logic [3:0] ex_aluop;
   data_t      ex_input1, ex_input2, ex_store_data;
   reg_idx_t   ex_dst;
   logic       ex_reg_write, ex_mem_read, ex_mem_write;

   modport master (
      output id_valid, id_aluop, id_rs, id_rt, id_dst, id_rs_data, id_rt_data, id_imm,
             id_use_imm, id_rt_used, id_reg_write, id_mem_read, id_mem_write, flush,
             exm_reg_write, exm_dst, exm_result, mwb_reg_write, mwb_dst, mwb_result,
      input  id_stall, ex_valid, ex_aluop, ex_input1, ex_input2, ex_store_data, ex_dst,
             ex_reg_write, ex_mem_read, ex_mem_write
   );

   modport slave (
      input  id_valid, id_aluop, id_rs, id_rt, id_dst, id_rs_data, id_rt_data, id_imm,
             id_use_imm, id_rt_used, id_reg_write, id_mem_read, id_mem_write, flush,
             exm_reg_write, exm_dst, exm_result, mwb_reg_write, mwb_dst, mwb_result,
      output id_stall, ex_valid, ex_aluop, ex_input1, ex_input2, ex_store_data, ex_dst,
             ex_reg_write, ex_mem_read, ex_mem_write
   );
endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// fwd_unit: load-use / RAW hazard detection and EX operand forwarding.
// FORWARD_EN defined: bypass from EX/MEM then MEM/WB; undefined: stall on any RAW.
module fwd_unit
   import alu_defs_pkg::*;
(
   input  logic     rst_n,
   input  logic     flush,
   input  logic     id_valid,
   input  logic     id_rt_used,
   input  reg_idx_t id_rs,
   input  reg_idx_t id_rt,
   input  logic     ex_valid,
   input  logic     ex_mem_read,
   input  logic     ex_reg_write,
   input  reg_idx_t ex_dst,
   input  reg_idx_t ex_rs,
   input  reg_idx_t ex_rt,
   input  data_t    ex_rs_data,
   input  data_t    ex_rt_data,
   input  logic     exm_reg_write,
   input  reg_idx_t exm_dst,
   input  data_t    exm_result,
   input  logic     mwb_reg_write,
   input  reg_idx_t mwb_dst,
   input  data_t    mwb_result,
   output logic     stall,
   output data_t    rs_fwd,
   output data_t    rt_fwd
);
   logic load_use, raw, unused_ok;

   assign load_use = ex_valid && ex_mem_read && (ex_dst != '0) && id_valid &&
                     ((ex_dst == id_rs) || (id_rt_used && (ex_dst == id_rt)));

`ifdef FORWARD_EN
   assign rs_fwd = fwd_pick(ex_rs, ex_rs_data, exm_reg_write, exm_dst, exm_result,
                            mwb_reg_write, mwb_dst, mwb_result);
   assign rt_fwd = fwd_pick(ex_rt, ex_rt_data, exm_reg_write, exm_dst, exm_result,
                            mwb_reg_write, mwb_dst, mwb_result);
   assign raw       = 1'b0;
   assign unused_ok = ex_reg_write;
`else
   logic rs_raw, rt_raw;
   assign rs_raw = reg_hit(id_rs, ex_valid && ex_reg_write, ex_dst) ||
                   reg_hit(id_rs, exm_reg_write, exm_dst) ||
                   reg_hit(id_rs, mwb_reg_write, mwb_dst);
   assign rt_raw = reg_hit(id_rt, ex_valid && ex_reg_write, ex_dst) ||
                   reg_hit(id_rt, exm_reg_write, exm_dst) ||
                   reg_hit(id_rt, mwb_reg_write, mwb_dst);
   assign raw       = id_valid && (rs_raw || (id_rt_used && rt_raw));
   assign rs_fwd    = ex_rs_data;
   assign rt_fwd    = ex_rt_data;
   assign unused_ok = ^{ex_rs, ex_rt, exm_result, mwb_result};
`endif

   // Flush kills the ID instruction, so there is nothing left to stall.
   assign stall = rst_n && !flush && (load_use || raw);
endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with bubble insertion; hazards and operand
// forwarding come from fwd_unit (forwarding gated by FORWARD_EN).
module id_ex_stage
   import alu_defs_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   id_ex_stage_if.slave bus
);
   ex_reg_t ex_q, ex_d;
   logic    stall;
   data_t   rs_fwd, rt_fwd;

   fwd_unit u_fwd (
      .rst_n         (rst_n),
      .flush         (bus.flush),
      .id_valid      (bus.id_valid),
      .id_rt_used    (bus.id_rt_used),
      .id_rs         (bus.id_rs),
      .id_rt         (bus.id_rt),
      .ex_valid      (ex_q.valid),
      .ex_mem_read   (ex_q.mem_read),
      .ex_reg_write  (ex_q.reg_write),
      .ex_dst        (ex_q.dst),
      .ex_rs         (ex_q.rs),
      .ex_rt         (ex_q.rt),
      .ex_rs_data    (ex_q.rs_data),
      .ex_rt_data    (ex_q.rt_data),
      .exm_reg_write (bus.exm_reg_write),
      .exm_dst       (bus.exm_dst),
      .exm_result    (bus.exm_result),
      .mwb_reg_write (bus.mwb_reg_write),
      .mwb_dst       (bus.mwb_dst),
      .mwb_result    (bus.mwb_result),
      .stall         (stall),
      .rs_fwd        (rs_fwd),
      .rt_fwd        (rt_fwd)
   );

   // A bubble is an all-zero register: invalid, no side effects, ALU_ADD.
   always_comb begin
      ex_d       = '0;
      ex_d.aluop = ALU_ADD;
      if (bus.id_valid && !bus.flush && !stall) begin
         ex_d.valid     = 1'b1;
         ex_d.aluop     = bus.id_aluop;
         ex_d.rs        = bus.id_rs;
         ex_d.rt        = bus.id_rt;
         ex_d.dst       = bus.id_dst;
         ex_d.rs_data   = bus.id_rs_data;
         ex_d.rt_data   = bus.id_rt_data;
         ex_d.imm       = bus.id_imm;
         ex_d.use_imm   = bus.id_use_imm;
         ex_d.reg_write = bus.id_reg_write;
         ex_d.mem_read  = bus.id_mem_read;
         ex_d.mem_write = bus.id_mem_write;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   assign bus.id_stall      = stall;
   assign bus.ex_valid      = ex_q.valid;
   assign bus.ex_aluop      = ex_q.aluop;
   assign bus.ex_input1     = rs_fwd;
   assign bus.ex_input2     = ex_q.use_imm ? ex_q.imm : rt_fwd;
   assign bus.ex_store_data = rt_fwd;
   assign bus.ex_dst        = ex_q.dst;
   assign bus.ex_reg_write  = ex_q.reg_write;
   assign bus.ex_mem_read   = ex_q.mem_read;
   assign bus.ex_mem_write  = ex_q.mem_write;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic against a
// history-of-issued-instructions reference model.
module tb_id_ex_stage;
   import alu_defs_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   last_stall = 0;

   id_ex_stage_if bus();
   id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      bit        valid;
      bit [3:0]  aluop;
      int        rs, rt, dst;
      bit [31:0] rs_data, rt_data, imm;
      bit        use_imm, reg_write, mem_read, mem_write;
   } instr_t;

   instr_t ex_hist[$];   // instructions in the order they occupied EX
   instr_t bubble_i;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit [31:0] m_opnd(int src, bit [31:0] v);
`ifdef FORWARD_EN
      if (src != 0 && bus.exm_reg_write && int'(bus.exm_dst) == src) return bus.exm_result;
      if (src != 0 && bus.mwb_reg_write && int'(bus.mwb_dst) == src) return bus.mwb_result;
`endif
      return v;
   endfunction

   function automatic bit exp_stall();
      instr_t e = ex_hist[$];
      int     w[3];
      bit     hz;
      int     rs = int'(bus.id_rs);
      int     rt = int'(bus.id_rt);
      if (!rst_n || bus.flush || !bus.id_valid) return 0;
      hz = e.valid && e.mem_read && e.dst != 0 && (e.dst == rs || (bus.id_rt_used && e.dst == rt));
      w[0] = (e.valid && e.reg_write) ? e.dst : 0;
      w[1] = bus.exm_reg_write ? int'(bus.exm_dst) : 0;
      w[2] = bus.mwb_reg_write ? int'(bus.mwb_dst) : 0;
`ifndef FORWARD_EN
      foreach (w[k]) if (w[k] != 0 && (w[k] == rs || (bus.id_rt_used && w[k] == rt))) hz = 1;
`endif
      return hz;
   endfunction

   task automatic check_all(string tag);
      instr_t    e = ex_hist[$];
      bit [31:0] rt_op = m_opnd(e.rt, e.rt_data);
      chk({tag, ".stall"}, bus.id_stall, exp_stall());
      chk({tag, ".valid"}, bus.ex_valid, e.valid);
      chk({tag, ".aluop"}, bus.ex_aluop, e.aluop);
      chk({tag, ".reg_write"}, bus.ex_reg_write, e.reg_write);
      chk({tag, ".mem_read"}, bus.ex_mem_read, e.mem_read);
      chk({tag, ".mem_write"}, bus.ex_mem_write, e.mem_write);
      if (e.valid) begin
         chk({tag, ".input1"}, bus.ex_input1, m_opnd(e.rs, e.rs_data));
         chk({tag, ".input2"}, bus.ex_input2, e.use_imm ? e.imm : rt_op);
         chk({tag, ".store"}, bus.ex_store_data, rt_op);
         chk({tag, ".dst"}, bus.ex_dst, e.dst);
      end
   endtask

   task automatic chk_zero(string tag);
      chk({tag, ".stall"}, bus.id_stall, 0);
      chk({tag, ".valid"}, bus.ex_valid, 0);
      chk({tag, ".aluop"}, bus.ex_aluop, 0);
      chk({tag, ".input1"}, bus.ex_input1, 0);
      chk({tag, ".input2"}, bus.ex_input2, 0);
      chk({tag, ".store"}, bus.ex_store_data, 0);
      chk({tag, ".dst"}, bus.ex_dst, 0);
      chk({tag, ".ctl"}, {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 0);
   endtask

   // Inputs are set at the falling edge; check, then let the rising edge commit.
   task automatic cycle(string tag);
      instr_t n = bubble_i;
      #1;
      check_all(tag);
      last_stall = exp_stall();
      if (rst_n && bus.id_valid && !bus.flush && !last_stall) begin
         n.valid = 1; n.aluop = bus.id_aluop;
         n.rs = int'(bus.id_rs); n.rt = int'(bus.id_rt); n.dst = int'(bus.id_dst);
         n.rs_data = bus.id_rs_data; n.rt_data = bus.id_rt_data; n.imm = bus.id_imm;
         n.use_imm = bus.id_use_imm; n.reg_write = bus.id_reg_write;
         n.mem_read = bus.id_mem_read; n.mem_write = bus.id_mem_write;
      end
      @(posedge clk);
      ex_hist.push_back(n);
      @(negedge clk);
   endtask

   task automatic set_id(bit v, int op, int rs, int rt, int dst, bit [31:0] rsd, bit [31:0] rtd,
                         bit [31:0] imm, bit ui, bit ru, bit rw, bit mr, bit mw);
      bus.id_valid = v; bus.id_aluop = op[3:0];
      bus.id_rs = rs[4:0]; bus.id_rt = rt[4:0]; bus.id_dst = dst[4:0];
      bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
      bus.id_use_imm = ui; bus.id_rt_used = ru;
      bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
   endtask

   task automatic set_byp(bit ew, int ed, bit [31:0] er, bit ww, int wd, bit [31:0] wr);
      bus.exm_reg_write = ew; bus.exm_dst = ed[4:0]; bus.exm_result = er;
      bus.mwb_reg_write = ww; bus.mwb_dst = wd[4:0]; bus.mwb_result = wr;
   endtask

   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      set_byp(0, 0, 0, 0, 0, 0);
      bus.flush = 0;
   endtask

   task automatic load_r4();
      idle();
      set_id(1, ALU_ADD, 0, 0, 4, 0, 0, 32'h8, 1, 0, 1, 1, 0);
      cycle("lw");
      set_id(1, ALU_SUB, 4, 0, 6, 32'h0BAD, 0, 0, 0, 0, 1, 0, 0);
   endtask

   initial begin
      ex_hist.push_back(bubble_i);
      // Reset with a busy ID and matching bypasses: everything must stay quiet.
      bus.flush = 0;
      set_id(1, ALU_OR, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 1, 1, 1, 1);
      set_byp(1, 1, 32'hAA, 1, 2, 32'hBB);
      #2 chk_zero("reset");
      cycle("reset");
      rst_n = 1;

      // ADD r3 = r1 + r2 with no hazards.
      idle();
      set_id(1, ALU_ADD, 1, 2, 3, 5, 7, 32'h99, 0, 1, 1, 0, 0);
      cycle("add");
      idle();
      #1;
      chk("add.input1", bus.ex_input1, 5);
      chk("add.input2", bus.ex_input2, 7);
      chk("add.dst", bus.ex_dst, 3);
      chk("add.valid", bus.ex_valid, 1);
      cycle("add_done");

      // EX/MEM beats MEM/WB for the same source register.
      set_id(1, ALU_ADD, 1, 2, 5, 32'hAA, 32'h3, 0, 0, 1, 1, 0, 0);
      cycle("prio_id");
      idle();
      set_byp(1, 1, 32'h10, 1, 1, 32'h20);
      #1;
`ifdef FORWARD_EN
      chk("prio.input1", bus.ex_input1, 32'h10);
`else
      chk("prio.input1", bus.ex_input1, 32'hAA);
`endif
      cycle("prio");

      // Register 0 is never forwarded.
      idle();
      set_id(1, ALU_ADD, 0, 0, 9, 0, 0, 0, 0, 1, 1, 0, 0);
      cycle("r0_id");
      idle();
      set_byp(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
      #1 chk("r0.input1", bus.ex_input1, 0);
      cycle("r0");

      // Load-use: one stall, one bubble, then the consumer enters.
      load_r4();
      #1 chk("lu.stall", bus.id_stall, 1);
      cycle("lu_stall");
      set_byp(1, 4, 32'h0, 0, 0, 0);
      cycle("lu_bubble");
`ifdef FORWARD_EN
      idle();
      set_byp(0, 0, 0, 1, 4, 32'h44);
      #1;
      chk("lu.valid", bus.ex_valid, 1);
      chk("lu.input1", bus.ex_input1, 32'h44);
      cycle("lu_enter");
`endif

      // Flush coincident with a load-use hazard: flush wins.
      load_r4();
      bus.flush = 1;
      #1 chk("flush.stall", bus.id_stall, 0);
      cycle("flush");
      idle();
      #1 chk("flush.valid", bus.ex_valid, 0);
      cycle("flush_after");

      // Reset in the middle of a stall, then a clean instruction.
      load_r4();
      #1 chk("rst_mid.stall", bus.id_stall, 1);
      #1 rst_n = 0;
      ex_hist.push_back(bubble_i);
      #1 chk_zero("rst_mid");
      cycle("rst_mid");
      rst_n = 1;
      idle();
      set_id(1, ALU_ADD, 1, 2, 7, 9, 3, 0, 0, 1, 1, 0, 0);
      cycle("post_rst");
      idle();
      #1;
      chk("post_rst.valid", bus.ex_valid, 1);
      chk("post_rst.input1", bus.ex_input1, 9);
      chk("post_rst.dst", bus.ex_dst, 7);
      cycle("post_rst_done");

      // Random traffic; a stalled instruction is re-presented unchanged.
      for (int i = 0; i < 400; i++) begin
         if (!last_stall)
            set_id($urandom_range(0, 7) != 0, $urandom_range(0, 5), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom, $urandom,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 3) == 0);
         bus.flush = ($urandom_range(0, 7) == 0);
         set_byp($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom);
         cycle("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
